// File: rtl/pipe_stage_buf.sv
// Handshaked pipeline stage register with exception flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant with a registered in_ready_o.
module pipe_stage_buf #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o,
  input  logic              stall_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rdy_q;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_xfer;
  logic                out_xfer;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign occ_o       = state_q;
  assign stall_cnt_o = cnt_q;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = out_valid_o & out_ready_i;

  // rdy_q keeps in_ready_o low through reset and for the release cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  if (CLEAR_DATA) begin : g_main_clr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) main_q <= '0;
      else        main_q <= main_d;
    end
  end else begin : g_main_keep
    always_ff @(posedge clk) begin
      main_q <= main_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_clr_i) begin
      cnt_d = '0;
    end else if (out_valid_o && !out_ready_i && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;

  if (CLEAR_DATA) begin : g_skid_clr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) skid_q <= '0;
      else        skid_q <= skid_d;
    end
  end else begin : g_skid_keep
    always_ff @(posedge clk) begin
      skid_q <= skid_d;
    end
  end

  // Depends only on registers, so out_ready_i never reaches in_ready_o.
  assign in_ready_o = rdy_q & (state_q != ST_TWO);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data_i;
        end else if (in_xfer) begin
          state_d = ST_TWO;
          skid_d  = in_data_i;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end
  end
`else
  assign in_ready_o = rdy_q & (!out_valid_o | out_ready_i);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end
      ST_ONE: begin
        // an input transfer while full implies the held beat left this cycle
        if (in_xfer) begin
          main_d = in_data_i;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      if (CLEAR_DATA) main_d = '0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: queue-level model compared every cycle plus directed literals.
// Follows PIPE_STAGE_SKID_EN like the design (capacity 2 with it, 1 without).
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam longint MAX1 = 65535;
  localparam longint MAX2 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        stall_clr = 1'b0;

  logic        in_ready_o, out_valid_o;
  logic [31:0] out_data_o;
  logic [1:0]  occ_o;
  logic [15:0] stall_cnt_o;
  logic        in_ready2, out_valid2;
  logic [31:0] out_data2;
  logic [1:0]  occ2;
  logic [1:0]  stall_cnt2;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_data_i(in_data),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o),
    .occ_o(occ_o), .stall_clr_i(stall_clr), .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_buf #(.DATA_W(32), .CNT_W(2), .CLEAR_DATA(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready2), .in_data_i(in_data),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_data_o(out_data2),
    .occ_o(occ2), .stall_clr_i(stall_clr), .stall_cnt_o(stall_cnt2)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a FIFO of capacity CAP, plus two saturating stall counters.
  logic [31:0] mq[$];
  logic [31:0] out_log[$];
  bit     m_rdy  = 1'b0;
  bit     m_zero = 1'b1;
  bit     m_acc  = 1'b0;
  longint m_cnt  = 0;
  longint m_cnt2 = 0;

  function automatic bit exp_in_ready();
    if (!m_rdy) return 1'b0;
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_rdy = 1'b0; m_zero = 1'b1; m_acc = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      bit ix, ox, st;
      ix = in_valid && exp_in_ready();
      ox = (mq.size() > 0) && out_ready;
      st = (mq.size() > 0) && !out_ready;
      if (stall_clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (st) begin
        if (m_cnt < MAX1) m_cnt++;
        if (m_cnt2 < MAX2) m_cnt2++;
      end
      m_acc = ix;
      if (flush) begin
        mq.delete();
        m_zero = 1'b1;
      end else begin
        if (ox) void'(mq.pop_front());
        if (ix) begin
          mq.push_back(in_data);
          m_zero = 1'b0;
        end
      end
      m_rdy = 1'b1;
    end
  end

  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    chk("in_ready", in_ready_o, exp_in_ready());
    chk("out_valid", out_valid_o, mq.size() > 0);
    chk("occ", occ_o, mq.size());
    if (mq.size() > 0) chk("out_data", out_data_o, mq[0]);
    else if (m_zero) chk("out_data_zero", out_data_o, 0);
    chk("stall_cnt", stall_cnt_o, m_cnt);
    chk("stall_cnt_w2", stall_cnt2, m_cnt2);
    chk("in_ready_w2", in_ready2, exp_in_ready());
    chk("occ_w2", occ2, mq.size());
    if (mq.size() > 0) chk("out_data_w2", out_data2, mq[0]);
    if (prev_stall && !prev_flush && rst_n) chk("out_data_stable", out_data_o, prev_data);
    if (out_valid_o && out_ready && rst_n) out_log.push_back(out_data_o);
    prev_stall = out_valid_o && !out_ready && rst_n;
    prev_flush = flush;
    prev_data  = out_data_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] seq[3];
    int idx;
    longint sat_exp[6];
    seq = '{32'hA, 32'hB, 32'hC};
    sat_exp = '{1, 2, 3, 3, 3, 3};

    // Power-on reset and release
    repeat (3) step();
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_low", in_ready_o, 0);
    step();
    chk("release_in_ready_high", in_ready_o, 1);

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1; in_data = k;
      step();
      chk("stream_data", out_data_o, k);
      chk("stream_valid", out_valid_o, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", out_valid_o, 0);
    chk("stream_stall", stall_cnt_o, 0);

    // Back-pressure with A, B, C
    out_log.delete();
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = seq[idx];
      step();
      if (m_acc) idx++;
    end
    chk("bp_accepted", idx, CAP);
    chk("bp_occ", occ_o, CAP);
    chk("bp_head", out_data_o, 32'hA);
    chk("bp_in_ready", in_ready_o, 0);
    chk("bp_stall", stall_cnt_o, 3);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_path", in_ready_o, (CAP == 2) ? 0 : 1);
    for (int c = 0; c < 20 && idx < 3; c++) begin
      in_valid = 1'b1; in_data = seq[idx];
      step();
      if (m_acc) idx++;
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("bp_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("bp_order0", out_log[0], 32'hA);
      chk("bp_order1", out_log[1], 32'hB);
      chk("bp_order2", out_log[2], 32'hC);
    end
    chk("bp_stall_hold", stall_cnt_o, 3);

    // Flush dominates a simultaneous input beat
    out_ready = 1'b0;
    for (int k = 0; k < CAP; k++) begin
      in_valid = 1'b1; in_data = 32'h11 * (k + 1);
      step();
    end
    chk("fl_occ_full", occ_o, CAP);
    out_log.delete();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid_o, 0);
    chk("fl_occ", occ_o, 0);
    chk("fl_data", out_data_o, 0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_no_dead", out_log.size(), 0);

    // Saturation on the 2-bit counter, clear wins during a stall
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("clr_cnt", stall_cnt_o, 0);
    chk("clr_cnt_w2", stall_cnt2, 0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sat_seq", stall_cnt2, sat_exp[i]);
    end
    chk("sat_wide", stall_cnt_o, 6);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("sat_clr", stall_cnt2, 0);
    step();
    chk("sat_restart", stall_cnt2, 1);
    out_ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset mid-stream while full
    out_ready = 1'b0;
    for (int k = 0; k < CAP; k++) begin
      in_valid = 1'b1; in_data = 32'h70 + k;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("mid_occ_full", occ_o, CAP);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_occ", occ_o, 0);
    chk("mid_rst_in_ready", in_ready_o, 0);
    chk("mid_rst_stall", stall_cnt_o, 0);
    chk("mid_rst_data", out_data_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("mid_release_low", in_ready_o, 0);
    step();
    chk("mid_release_high", in_ready_o, 1);

    // Random valid/ready with occasional flush and counter clear
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 99) < 2);
      stall_clr = ($urandom_range(0, 49) == 0);
      step();
    end
    flush = 1'b0; stall_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("final_empty", out_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
